// File: rtl/rp_seq_ctrl.sv
// Chunk sequencer for the sparse-HDC class-HV mux: clears the similarity accumulator,
// walks ctr over the unpruned chunks under downstream stall, drains the pipe, then pulses done.
module rp_seq_ctrl #(
  parameter int SEQ_CYCLE_COUNT = 4,
  parameter int CTR_W           = 2,
  parameter int PIPE_LAT        = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [2:0]       cfg_num_chunks,
  input  logic             stall,
  output logic [CTR_W-1:0] ctr,
  output logic             chunk_valid,
  output logic             acc_clear,
  output logic             last_chunk,
  output logic             busy,
  output logic             done
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0]    DRAIN_INIT = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [CTR_W-1:0] MAX_IDX    = CTR_W'(SEQ_CYCLE_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CTR_W-1:0] last_idx, last_idx_nx;
  logic [CTR_W-1:0] ctr_nx;
  logic [CTR_W-1:0] cfg_idx;
  logic [DW-1:0]    drain_cnt, drain_cnt_nx;
  logic             cv_nx, clr_nx, lc_nx, busy_nx, done_nx;

  // The pass is tracked by the index of its final chunk, so ctr can be compared directly.
  always_comb begin
    cfg_idx = MAX_IDX;
    if (cfg_num_chunks != 3'd0 && int'(cfg_num_chunks) <= SEQ_CYCLE_COUNT)
      cfg_idx = CTR_W'(cfg_num_chunks - 3'd1);
  end

  always_comb begin
    state_nx     = state;
    ctr_nx       = ctr;
    last_idx_nx  = last_idx;
    drain_cnt_nx = drain_cnt;
    cv_nx        = 1'b0;
    clr_nx       = 1'b0;
    lc_nx        = 1'b0;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;

    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          state_nx    = S_CLEAR;
          clr_nx      = 1'b1;
          busy_nx     = 1'b1;
          last_idx_nx = cfg_idx;
          ctr_nx      = '0;
        end
      end

      S_CLEAR: begin
        state_nx = S_RUN;
        ctr_nx   = '0;
        cv_nx    = ~stall;
        lc_nx    = ~stall && (last_idx == '0);
      end

      S_RUN: begin
        if (chunk_valid && last_chunk) begin
          ctr_nx = '0;
          if (PIPE_LAT == 0) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx     = S_DRAIN;
            drain_cnt_nx = DRAIN_INIT;
          end
        end else begin
          // A consumed chunk advances ctr; a stalled one holds it for the retry.
          if (chunk_valid)
            ctr_nx = ctr + 1'b1;
          cv_nx = ~stall;
          lc_nx = ~stall && (ctr_nx == last_idx);
        end
      end

      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end else begin
          drain_cnt_nx = drain_cnt - 1'b1;
        end
      end

      S_DONE: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end

      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      ctr         <= '0;
      last_idx    <= '0;
      drain_cnt   <= '0;
      chunk_valid <= 1'b0;
      acc_clear   <= 1'b0;
      last_chunk  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      ctr         <= ctr_nx;
      last_idx    <= last_idx_nx;
      drain_cnt   <= drain_cnt_nx;
      chunk_valid <= cv_nx;
      acc_clear   <= clr_nx;
      last_chunk  <= lc_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_rp_seq_ctrl.sv
// Bench for rp_seq_ctrl: per-edge expected timelines are built from the pass rules
// (clear, issue n chunks skipping stalled edges, drain PIPE_LAT, done) and compared each cycle.
module tb_rp_seq_ctrl;

  localparam int SEQ = 4;
  localparam int PL  = 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic [2:0] cfg_num_chunks;
  logic       stall;
  logic [1:0] ctr;
  logic       chunk_valid, acc_clear, last_chunk, busy, done;

  int total = 0;
  int bad   = 0;

  rp_seq_ctrl #(
    .SEQ_CYCLE_COUNT(SEQ),
    .CTR_W(2),
    .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .cfg_num_chunks(cfg_num_chunks),
    .stall(stall),
    .ctr(ctr),
    .chunk_valid(chunk_valid),
    .acc_clear(acc_clear),
    .last_chunk(last_chunk),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // One pass. Edge 0 samples start; index e holds the outputs seen after edge e.
  // Stall sampled at edge e decides whether a chunk is issued after edge e.
  // pct < 0 selects the fixed stall mask instead of random stall.
  task automatic do_pass(input logic [2:0] cfg, input int pct, input logic [63:0] mask,
                         input bit noise, input bit hold, input string tag);
    int   n, issued, last_e, d;
    bit   st[0:127];
    int   e_ctr[0:127];
    bit   e_cv[0:127], e_lc[0:127], e_clr[0:127], e_done[0:127], e_busy[0:127];
    n = (cfg == 3'd0 || int'(cfg) > SEQ) ? SEQ : int'(cfg);
    for (int e = 0; e < 128; e++) begin
      e_ctr[e] = 0; e_cv[e] = 0; e_lc[e] = 0; e_clr[e] = 0; e_done[e] = 0; e_busy[e] = 0;
      if (e == 0 || e >= 40) st[e] = 1'b0;
      else if (pct < 0)      st[e] = (e < 64) ? mask[e] : 1'b0;
      else                   st[e] = ($urandom_range(0, 99) < pct);
    end
    e_clr[0] = 1;
    issued = 0;
    last_e = 0;
    for (int e = 1; issued < n; e++) begin
      e_ctr[e] = issued;
      if (!st[e]) begin
        e_cv[e] = 1;
        if (issued == n - 1) begin
          e_lc[e] = 1;
          last_e  = e;
        end
        issued++;
      end
    end
    d = last_e + 1 + PL;
    e_done[d] = 1;
    for (int e = 0; e <= d; e++) e_busy[e] = 1;

    start = 1'b1;
    cfg_num_chunks = cfg;
    stall = 1'b0;
    @(posedge clk);
    for (int e = 0; e <= d + 1; e++) begin
      @(negedge clk);
      total++;
      if (int'(ctr) !== e_ctr[e]) begin
        bad++;
        $display("FAIL %s ctr edge=%0d got=%0d want=%0d", tag, e, ctr, e_ctr[e]);
      end
      total++;
      if (chunk_valid !== e_cv[e]) begin
        bad++;
        $display("FAIL %s chunk_valid edge=%0d got=%b want=%b", tag, e, chunk_valid, e_cv[e]);
      end
      total++;
      if (last_chunk !== e_lc[e]) begin
        bad++;
        $display("FAIL %s last_chunk edge=%0d got=%b want=%b", tag, e, last_chunk, e_lc[e]);
      end
      total++;
      if (acc_clear !== e_clr[e]) begin
        bad++;
        $display("FAIL %s acc_clear edge=%0d got=%b want=%b", tag, e, acc_clear, e_clr[e]);
      end
      total++;
      if (done !== e_done[e]) begin
        bad++;
        $display("FAIL %s done edge=%0d got=%b want=%b", tag, e, done, e_done[e]);
      end
      total++;
      if (busy !== e_busy[e]) begin
        bad++;
        $display("FAIL %s busy edge=%0d got=%b want=%b", tag, e, busy, e_busy[e]);
      end
      stall = st[e + 1];
      cfg_num_chunks = 3'($urandom_range(0, 7));
      if (hold)                     start = 1'b1;
      else if (noise && e + 1 <= d + 1) start = 1'($urandom_range(0, 1));
      else                          start = 1'b0;
      if (e < d + 1) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    cfg_num_chunks = 3'd4;
    #1;
    total++;
    if ({ctr, chunk_valid, acc_clear, last_chunk, busy, done} !== 7'd0) begin
      bad++;
      $display("FAIL reset_hold outs got=%b want=0", {ctr, chunk_valid, acc_clear, last_chunk, busy, done});
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ctr, chunk_valid, acc_clear, last_chunk, busy, done} !== 7'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=0", i, {ctr, chunk_valid, acc_clear, last_chunk, busy, done});
      end
    end
  endtask

  task automatic test_nominal();
    do_pass(3'd4, 0, 64'd0, 1'b0, 1'b0, "nominal");
  endtask

  task automatic test_pruned();
    do_pass(3'd2, 0, 64'd0, 1'b0, 1'b0, "prune2");
    do_pass(3'd1, 0, 64'd0, 1'b0, 1'b0, "prune1");
    do_pass(3'd3, 0, 64'd0, 1'b0, 1'b0, "prune3");
  endtask

  task automatic test_stall();
    do_pass(3'd4, -1, 64'h1C, 1'b0, 1'b0, "stall_fixed");
    do_pass(3'd4, -1, 64'h02, 1'b0, 1'b0, "stall_first");
    do_pass(3'd3, 40, 64'd0, 1'b0, 1'b0, "stall_rand");
  endtask

  task automatic test_clamp();
    do_pass(3'd0, 0, 64'd0, 1'b0, 1'b0, "clamp0");
    do_pass(3'd7, 0, 64'd0, 1'b0, 1'b0, "clamp7");
    do_pass(3'd5, 0, 64'd0, 1'b0, 1'b0, "clamp5");
  endtask

  task automatic test_busy_start();
    do_pass(3'd4, 0, 64'd0, 1'b1, 1'b0, "busy_start");
  endtask

  task automatic test_back_to_back();
    do_pass(3'd4, 0, 64'd0, 1'b0, 1'b1, "b2b_first");
    do_pass(3'd3, 20, 64'd0, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    cfg_num_chunks = 3'd4;
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    #1;
    total++;
    if ({ctr, chunk_valid, acc_clear, last_chunk, busy, done} !== 7'd0) begin
      bad++;
      $display("FAIL mid_reset async got=%b want=0", {ctr, chunk_valid, acc_clear, last_chunk, busy, done});
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset no_done cyc=%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    do_pass(3'd4, 0, 64'd0, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      do_pass(3'($urandom_range(0, 7)), 30, 64'd0, 1'b1, 1'($urandom_range(0, 1)), "random");
    do_pass(3'd2, 0, 64'd0, 1'b0, 1'b0, "random_tail");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_pruned();
    test_stall();
    test_clamp();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
